// File: rtl/fsm_jump_loader.sv
`default_nettype none
// =============================================================================
// Module   : fsm_jump_loader
// Brief    : Loads a five-word jump table over a valid/ready port, checks it,
//            and arms it towards a sequenced FSM with an ok strobe.
//            Optional macro FSM_JUMP_ONEHOT_CHECK_EN rejects multi-bit words.
// Revision : 1.0 - initial release
// =============================================================================
module fsm_jump_loader #(
    parameter int OK_PULSE_LEN = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [4:0] jump1,
    output logic [4:0] jump2,
    output logic [4:0] jump3,
    output logic [4:0] jump4,
    output logic [4:0] jump5,
    output logic       ok,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] C_OK_LAST  = 4'(OK_PULSE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ARM   = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [4:0][4:0]  shadow_q, shadow_d;
    logic [4:0][4:0]  jump_q, jump_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [3:0]       okc_q, okc_d;
    logic             wr_ready_q, wr_ready_d;
    logic             ok_q, ok_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept;
    logic             table_bad;

    assign accept = wr_valid && wr_ready_q;

`ifdef FSM_JUMP_ONEHOT_CHECK_EN
    function automatic logic multi_bit(input logic [4:0] w);
        return (w & (w - 5'd1)) != 5'd0;
    endfunction

    always_comb begin
        table_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            table_bad = table_bad | multi_bit(shadow_q[k]);
        end
    end
`else
    assign table_bad = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        jump_d   = jump_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        okc_d    = okc_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = 3'd0;
                    tmo_d   = 8'd0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    for (int k = 0; k < 5; k++) begin
                        if (idx_q == 3'(k)) shadow_d[k] = wr_data;
                    end
                    idx_d = idx_q + 3'd1;
                    tmo_d = 8'd0;
                    if (idx_q == 3'd4) state_d = S_CHECK;
                end else if (tmo_q == C_TMO_LAST) begin
                    // A stalled load never reaches the outputs: drop the partial table.
                    state_d  = S_ERROR;
                    shadow_d = '0;
                    idx_d    = 3'd0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_CHECK: begin
                if (table_bad) begin
                    state_d  = S_ERROR;
                    shadow_d = '0;
                end else begin
                    state_d = S_ARM;
                    jump_d  = shadow_q;
                    okc_d   = 4'd0;
                end
            end
            S_ARM: begin
                if (okc_q == C_OK_LAST) state_d = S_RUN;
                else                    okc_d   = okc_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        wr_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d == S_LOAD) || (state_d == S_CHECK) || (state_d == S_ARM);
        ok_d       = (state_d == S_ARM);
        done_d     = (state_d == S_RUN);
        err_d      = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shadow_q   <= '0;
            jump_q     <= '0;
            idx_q      <= 3'd0;
            tmo_q      <= 8'd0;
            okc_q      <= 4'd0;
            wr_ready_q <= 1'b0;
            ok_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            jump_q     <= jump_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            okc_q      <= okc_d;
            wr_ready_q <= wr_ready_d;
            ok_q       <= ok_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign wr_ready = wr_ready_q;
    assign jump1    = jump_q[0];
    assign jump2    = jump_q[1];
    assign jump3    = jump_q[2];
    assign jump4    = jump_q[3];
    assign jump5    = jump_q[4];
    assign ok       = ok_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_jump_loader.sv
`default_nettype none
// =============================================================================
// Module   : tb_fsm_jump_loader
// Brief    : Scoreboard bench for fsm_jump_loader; two instances differing in
//            ok pulse length share the stimulus.
// Revision : 1.0 - initial release
// =============================================================================
module tb_fsm_jump_loader;

    localparam int TO = 4;
    localparam int NA = 1;
    localparam int NB = 3;
`ifdef FSM_JUMP_ONEHOT_CHECK_EN
    localparam bit ONEHOT_EN = 1'b1;
`else
    localparam bit ONEHOT_EN = 1'b0;
`endif

    typedef struct {
        bit              is_err;
        int              cyc;
        logic [4:0][4:0] tbl;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset, start, wr_valid;
    logic [4:0]      wr_data;
    logic [1:0]      wr_ready, ok, busy, done, err;
    logic [4:0][4:0] jmp_0, jmp_1;

    int              cyc = 0;
    int              vectors = 0;
    int              miscompares = 0;
    exp_t            exp_q[$];
    int              rd[2];
    logic [4:0][4:0] armed[2];
    bit              okp[2], errp[2];
    int              okcnt[2];

    fsm_jump_loader #(.OK_PULSE_LEN(NA), .TIMEOUT(TO)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready[0]), .jump1(jmp_0[0]), .jump2(jmp_0[1]), .jump3(jmp_0[2]),
        .jump4(jmp_0[3]), .jump5(jmp_0[4]), .ok(ok[0]), .busy(busy[0]), .done(done[0]),
        .err(err[0])
    );

    fsm_jump_loader #(.OK_PULSE_LEN(NB), .TIMEOUT(TO)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready[1]), .jump1(jmp_1[0]), .jump2(jmp_1[1]), .jump3(jmp_1[2]),
        .jump4(jmp_1[3]), .jump5(jmp_1[4]), .ok(ok[1]), .busy(busy[1]), .done(done[1]),
        .err(err[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nlen(input int i);
        return (i == 0) ? NA : NB;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, i, cyc, act, expv);
        end
    endtask

    task automatic mon(input int i, input logic okv, input logic errv, input logic donev,
                       input logic busyv, input logic [4:0][4:0] jv);
        if (okv && !okp[i]) begin
            if (rd[i] < exp_q.size() && !exp_q[rd[i]].is_err) begin
                chk("ok_start_cycle", i, exp_q[rd[i]].cyc, cyc);
                armed[i] = exp_q[rd[i]].tbl;
                rd[i]++;
            end else begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ok inst%0d cycle %0d: got ok=1 expected no arm", i, cyc);
            end
            chk("busy_in_arm", i, 32'(busyv), 32'd1);
            okcnt[i] = 0;
        end
        if (okv) okcnt[i]++;
        if (!okv && okp[i]) begin
            chk("ok_pulse_len", i, okcnt[i], nlen(i));
            chk("done_after_arm", i, {30'd0, donev, busyv}, 32'b10);
        end
        if (errv && !errp[i]) begin
            if (rd[i] < exp_q.size() && exp_q[rd[i]].is_err) begin
                chk("err_cycle", i, cyc, exp_q[rd[i]].cyc);
                rd[i]++;
            end else begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_err inst%0d cycle %0d: got err=1 expected no error", i, cyc);
            end
            chk("flags_in_err", i, {29'd0, okv, donev, busyv}, 32'd0);
        end
        chk("jump_table", i, 32'(jv), 32'(armed[i]));
        okp[i]  = okv;
        errp[i] = errv;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                armed[i] = '0;
                okp[i]   = 1'b0;
                errp[i]  = 1'b0;
                okcnt[i] = 0;
            end
        end else begin
            mon(0, ok[0], err[0], done[0], busy[0], jmp_0);
            mon(1, ok[1], err[1], done[1], busy[1], jmp_1);
        end
    end

    task automatic check_zero(input string nm);
        chk(nm, 0, 32'({wr_ready[0], ok[0], busy[0], done[0], err[0], jmp_0}), 32'd0);
        chk(nm, 1, 32'({wr_ready[1], ok[1], busy[1], done[1], err[1], jmp_1}), 32'd0);
    endtask

    // Called at #1 after a posedge; the current cycle carries the start request.
    task automatic session(input logic [4:0][4:0] w, input logic [4:0][3:0] g);
        exp_t e;
        int   prev;
        int   n;
        e.is_err = 1'b0;
        e.tbl    = w;
        e.cyc    = 0;
        prev     = cyc;
        for (int k = 0; k < 5; k++) begin
            if (!e.is_err) begin
                if (int'(g[k]) >= TO) begin
                    e.is_err = 1'b1;
                    e.cyc    = prev + TO + 1;
                end else begin
                    prev = prev + 1 + int'(g[k]);
                end
            end
        end
        if (!e.is_err) begin
            e.cyc = prev + 2;
            if (ONEHOT_EN) begin
                for (int k = 0; k < 5; k++) if ($countones(w[k]) > 1) e.is_err = 1'b1;
            end
        end
        exp_q.push_back(e);

        start    = 1'b1;
        wr_valid = 1'($urandom % 2);
        wr_data  = 5'($urandom);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++)
            chk("load_entry", i, {27'd0, err[i], busy[i], wr_ready[i], done[i], ok[i]}, 32'b01100);
        for (int k = 0; k < 5; k++) begin
            n = (int'(g[k]) >= TO) ? TO : int'(g[k]);
            repeat (n) begin
                wr_valid = 1'b0;
                wr_data  = 5'($urandom);
                start    = ($urandom % 4 == 0);
                @(posedge clk); #1;
            end
            if (int'(g[k]) >= TO) break;
            wr_valid = 1'b1;
            wr_data  = w[k];
            start    = ($urandom % 4 == 0);
            @(posedge clk); #1;
        end
        start    = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy != 2'b00 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (busy != 2'b00) begin
            miscompares++;
            $display("FAIL idle_wait: got busy=%b expected 00 after %0d cycles", busy, n);
        end
        repeat (2 + $urandom % 3) begin
            wr_valid = 1'($urandom % 2);
            wr_data  = 5'($urandom);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        logic [4:0][4:0] w;
        logic [4:0][3:0] g;
        for (int i = 0; i < 2; i++) rd[i] = 0;
        reset    = 1'b1;
        start    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b0;
        @(posedge clk); #1;

        session({5'h10, 5'h08, 5'h04, 5'h02, 5'h01}, '0);
        wait_idle();
        session({5'h01, 5'h02, 5'h04, 5'h08, 5'h10}, {4'd3, 4'd3, 4'd3, 4'd3, 4'd3});
        wait_idle();
        session({5'h10, 5'h08, 5'h04, 5'h02, 5'h01}, {4'd0, 4'd0, 4'd4, 4'd0, 4'd0});
        wait_idle();
        session({5'h10, 5'h08, 5'h04, 5'h03, 5'h01}, '0);
        wait_idle();

        for (int s = 0; s < 40; s++) begin
            for (int k = 0; k < 5; k++) begin
                w[k] = ($urandom % 2 == 1) ? 5'(($urandom % 6 == 5) ? 0 : (1 << ($urandom % 5)))
                                           : 5'($urandom);
                g[k] = ($urandom % 16 == 0) ? 4'($urandom_range(TO, TO + 2))
                                            : 4'($urandom_range(0, 2));
            end
            session(w, g);
            wait_idle();
        end

        // Arm a known table, then reset in the middle of a reload.
        session({5'h10, 5'h08, 5'h04, 5'h02, 5'h01}, '0);
        wait_idle();
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 5'h02;
        @(posedge clk); #1;
        wr_data = 5'h04;
        @(posedge clk); #1;
        wr_data = 5'h08;
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset_midload");
        @(posedge clk); #1;
        reset    = 1'b0;
        wr_valid = 1'b0;
        check_zero("idle_after_reset");
        @(posedge clk); #1;

        session({5'h10, 5'h08, 5'h04, 5'h02, 5'h01}, '0);
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) chk("events_consumed", i, rd[i], exp_q.size());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
